// File: rtl/io_tile_cfg.sv
// io_tile_cfg: fabric-edge IO tile routing pads <-> interconnect tracks from a double-buffered serial config.
// Latency: pad output 0 cycles (reg=0) or 1 cycle (reg=1); pad-to-track 0 cycles, or 2 with IO_TILE_CFG_INPUT_SYNC_EN.
// Backpressure: none; config shifts on config_enable and commits on config_load, every other path is free-running.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   data_from_io         pad input values        -> data_to_ic (track mux)
//   data_from_ic         track values into tile  -> data_to_io / data_oe (pad mux)
//   config_in/out        serial shadow chain, LSB of the chain leaves first
//   config_enable        shift strobe for the shadow chain
//   config_load          commit strobe, shadow chain -> active register
// Optional: define IO_TILE_CFG_INPUT_SYNC_EN to put a 2-flop synchroniser on data_from_io.
module io_tile_cfg #(
    parameter int IO_PAIRS = 4,
    parameter int IC_PAIRS = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IO_PAIRS-1:0] data_from_io,
    output logic [IO_PAIRS-1:0] data_to_io,
    output logic [IO_PAIRS-1:0] data_oe,
    input  logic [IC_PAIRS-1:0] data_from_ic,
    output logic [IC_PAIRS-1:0] data_to_ic,
    input  logic                config_in,
    output logic                config_out,
    input  logic                config_enable,
    input  logic                config_load
);

    localparam int SWI      = (IC_PAIRS > 1) ? $clog2(IC_PAIRS) : 1;
    localparam int SWO      = (IO_PAIRS > 1) ? $clog2(IO_PAIRS) : 1;
    localparam int IOW      = SWI + 3;
    localparam int ICW      = SWO + 1;
    localparam int IC_BASE  = IO_PAIRS * IOW;
    localparam int CFG_BITS = IC_BASE + IC_PAIRS * ICW;

    logic [CFG_BITS-1:0] chain_q, chain_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [IO_PAIRS-1:0] pad_v;
    logic [IO_PAIRS-1:0] pad_q;
    logic [IO_PAIRS-1:0] pad_src;

    // active_d samples chain_q (not chain_d) so a load coinciding with a
    // shift commits the pre-shift contents.
    always_comb begin
        chain_d  = chain_q;
        active_d = active_q;
        if (config_enable) begin
            chain_d = {config_in, chain_q[CFG_BITS-1:1]};
        end
        if (config_load) begin
            active_d = chain_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            chain_q  <= '0;
            active_q <= '0;
            pad_q    <= '0;
        end else begin
            chain_q  <= chain_d;
            active_q <= active_d;
            pad_q    <= pad_v;
        end
    end

    assign config_out = chain_q[0];

`ifdef IO_TILE_CFG_INPUT_SYNC_EN
    logic [IO_PAIRS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= data_from_io;
            sync2_q <= sync1_q;
        end
    end

    assign pad_src = sync2_q;
`else
    assign pad_src = data_from_io;
`endif

    // Pad side: select a track, optionally invert, optionally register.
    // Selects beyond IC_PAIRS match no track and yield 0.
    for (genvar i = 0; i < IO_PAIRS; i++) begin : g_pad
        logic [SWI-1:0] sel;
        logic           oe, rg, inv, c;

        assign sel = active_q[i*IOW +: SWI];
        assign oe  = active_q[i*IOW + SWI];
        assign rg  = active_q[i*IOW + SWI + 1];
        assign inv = active_q[i*IOW + SWI + 2];

        always_comb begin
            c = 1'b0;
            for (int k = 0; k < IC_PAIRS; k++) begin
                if (sel == SWI'(k)) begin
                    c = data_from_ic[k];
                end
            end
        end

        assign pad_v[i]      = c ^ inv;
        assign data_to_io[i] = oe & (rg ? pad_q[i] : pad_v[i]);
        assign data_oe[i]    = oe;
    end

    // Track side: select a pad when enabled; out-of-range selects yield 0.
    for (genvar j = 0; j < IC_PAIRS; j++) begin : g_trk
        logic [SWO-1:0] sel;
        logic           en, c;

        assign sel = active_q[IC_BASE + j*ICW +: SWO];
        assign en  = active_q[IC_BASE + j*ICW + SWO];

        always_comb begin
            c = 1'b0;
            for (int k = 0; k < IO_PAIRS; k++) begin
                if (sel == SWO'(k)) begin
                    c = pad_src[k];
                end
            end
        end

        assign data_to_ic[j] = en & c;
    end

endmodule

// File: tb/tb_io_tile_cfg.sv
module tb_io_tile_cfg;

    localparam int IOP = 4;
    localparam int ICP = 10;
    localparam int CFG = 58;
`ifdef IO_TILE_CFG_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [IOP-1:0] data_from_io;
    logic [IOP-1:0] data_to_io;
    logic [IOP-1:0] data_oe;
    logic [ICP-1:0] data_from_ic;
    logic [ICP-1:0] data_to_ic;
    logic           config_in;
    logic           config_out;
    logic           config_enable;
    logic           config_load;

    io_tile_cfg #(.IO_PAIRS(IOP), .IC_PAIRS(ICP)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_from_io  (data_from_io),
        .data_to_io    (data_to_io),
        .data_oe       (data_oe),
        .data_from_ic  (data_from_ic),
        .data_to_ic    (data_to_ic),
        .config_in     (config_in),
        .config_out    (config_out),
        .config_enable (config_enable),
        .config_load   (config_load)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       nm;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb[$];
    sb_t         e;
    logic [63:0] obs;
    int          checks = 0;
    int          errors = 0;

    // Config field builders: IO field i at i*7 = {inv, reg, oe, sel[3:0]},
    // IC field j at 28 + j*3 = {en, sel[1:0]}.
    function automatic logic [CFG-1:0] io_fld(logic [CFG-1:0] c, int i, int sel, bit oe, bit rg, bit inv);
        c[i*7 +: 4] = 4'(sel);
        c[i*7 + 4]  = oe;
        c[i*7 + 5]  = rg;
        c[i*7 + 6]  = inv;
        return c;
    endfunction

    function automatic logic [CFG-1:0] ic_fld(logic [CFG-1:0] c, int j, int sel, bit en);
        c[28 + j*3 +: 2] = 2'(sel);
        c[28 + j*3 + 2]  = en;
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic shift_cfg(input logic [CFG-1:0] v);
        for (int b = 0; b < CFG; b++) begin
            config_in     = v[b];
            config_enable = 1'b1;
            tick();
        end
        config_enable = 1'b0;
        config_in     = 1'b0;
    endtask

    task automatic load_cfg();
        config_load = 1'b1;
        tick();
        config_load = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        config_enable = 1'b1;
        config_load   = 1'b1;
        config_in     = 1'b1;
        data_from_io  = IOP'($urandom);
        data_from_ic  = ICP'($urandom);
        tick();
        data_from_io  = IOP'($urandom);
        data_from_ic  = ICP'($urandom);
        tick();
        reset         = 1'b0;
        config_enable = 1'b0;
        config_load   = 1'b0;
        config_in     = 1'b0;
        sb.push_back('{nm: "rst_to_io",   exp: 64'd0});
        sb.push_back('{nm: "rst_oe",      exp: 64'd0});
        sb.push_back('{nm: "rst_to_ic",   exp: 64'd0});
        sb.push_back('{nm: "rst_cfg_out", exp: 64'd0});
        #1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       obs = 64'(data_to_io);
                1:       obs = 64'(data_oe);
                2:       obs = 64'(data_to_ic);
                default: obs = 64'(config_out);
            endcase
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
            end
        end
    endtask

    task automatic test_shift_through();
        logic [CFG-1:0] pat;
        pat = 58'h2AB_CDEF_0123_4567;
        for (int b = 0; b < CFG; b++) begin
            config_in     = pat[b];
            config_enable = 1'b1;
            sb.push_back('{nm: "shift_cfg_out", exp: 64'(pat[b])});
            tick();
        end
        for (int b = 0; b < CFG; b++) begin
            config_in     = 1'b0;
            config_enable = 1'b1;
            #1;
            obs = 64'(config_out);
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s bit %0d got %0h expected %0h", e.nm, b, obs, e.exp);
            end
            tick();
        end
        config_enable = 1'b0;
        sb.push_back('{nm: "shift_oe_untouched", exp: 64'd0});
        #1;
        obs = 64'(data_oe);
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
        end
    endtask

    task automatic test_comb_route();
        logic [CFG-1:0] cfg;
        logic [ICP-1:0] dic;
        cfg = io_fld('0, 2, 7, 1'b1, 1'b0, 1'b0);
        shift_cfg(cfg);
        sb.push_back('{nm: "comb_oe_before_load", exp: 64'd0});
        #1;
        obs = 64'(data_oe);
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
        end
        load_cfg();
        for (int k = 0; k < 4; k++) begin
            dic          = ICP'($urandom);
            dic[7]       = k[0];
            data_from_ic = dic;
            sb.push_back('{nm: "comb_to_io", exp: 64'({1'b0, k[0], 2'b00})});
            sb.push_back('{nm: "comb_oe",    exp: 64'(4'b0100)});
            #1;
            obs = 64'(data_to_io);
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d got %0h expected %0h", e.nm, k, obs, e.exp);
            end
            obs = 64'(data_oe);
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d got %0h expected %0h", e.nm, k, obs, e.exp);
            end
            tick();
        end
    endtask

    task automatic test_reg_inv();
        logic [CFG-1:0] cfg;
        logic [ICP-1:0] dic;
        logic           seq_in [4];
        logic [3:0]     seq_exp [4];
        cfg = io_fld('0, 0, 3, 1'b1, 1'b1, 1'b1);
        shift_cfg(cfg);
        load_cfg();
        dic          = ICP'($urandom);
        dic[3]       = 1'b0;
        data_from_ic = dic;
        tick();
        // Each row: drive bit 3, sample before the edge, then after it.
        seq_in[0] = 1'b1; seq_exp[0] = 4'b0001;
        seq_in[1] = 1'b1; seq_exp[1] = 4'b0000;
        seq_in[2] = 1'b0; seq_exp[2] = 4'b0000;
        seq_in[3] = 1'b0; seq_exp[3] = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            dic          = ICP'($urandom);
            dic[3]       = seq_in[k];
            data_from_ic = dic;
            if (k == 1 || k == 3) begin
                tick();
            end
            sb.push_back('{nm: "reg_inv_to_io", exp: 64'(seq_exp[k])});
            #1;
            obs = 64'(data_to_io);
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s step %0d got %0h expected %0h", e.nm, k, obs, e.exp);
            end
        end
        sb.push_back('{nm: "reg_inv_oe", exp: 64'(4'b0001)});
        obs = 64'(data_oe);
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
        end
    endtask

    task automatic test_oor_track();
        logic [CFG-1:0] cfg;
        cfg = io_fld('0, 1, 12, 1'b1, 1'b0, 1'b0);
        cfg = io_fld(cfg, 3, 9, 1'b1, 1'b0, 1'b0);
        cfg = ic_fld(cfg, 9, 3, 1'b1);
        cfg = ic_fld(cfg, 0, 3, 1'b0);
        shift_cfg(cfg);
        load_cfg();
        data_from_ic = 10'h3FF;
        data_from_io = 4'b0000;
        tick();
        tick();
        tick();
        sb.push_back('{nm: "oor_to_io", exp: 64'(4'b1000)});
        sb.push_back('{nm: "oor_oe",    exp: 64'(4'b1010)});
        sb.push_back('{nm: "trk_idle",  exp: 64'd0});
        #1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       obs = 64'(data_to_io);
                1:       obs = 64'(data_oe);
                default: obs = 64'(data_to_ic);
            endcase
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
            end
        end
        tick();
        data_from_io = 4'b1000;
        for (int c = 0; c <= LAT; c++) begin
            sb.push_back('{nm: "trk_rise", exp: (c == LAT) ? 64'h200 : 64'd0});
            #1;
            obs = 64'(data_to_ic);
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cycle %0d got %0h expected %0h", e.nm, c, obs, e.exp);
            end
            if (c < LAT) begin
                tick();
            end
        end
        tick();
        data_from_io = 4'b0111;
        data_from_ic = 10'h1FF;
        for (int c = 0; c < LAT; c++) begin
            tick();
        end
        sb.push_back('{nm: "trk_fall",      exp: 64'd0});
        sb.push_back('{nm: "pad9_boundary", exp: 64'd0});
        #1;
        obs = 64'(data_to_ic);
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
        end
        obs = 64'(data_to_io);
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
        end
    endtask

    task automatic test_simul_shift_load();
        logic [CFG-1:0] a;
        logic [ICP-1:0] dic;
        do_reset();
        a = io_fld('0, 0, 5, 1'b1, 1'b0, 1'b0);
        a = io_fld(a, 1, 0, 1'b0, 1'b1, 1'b0);
        shift_cfg(a);
        config_in     = 1'b0;
        config_enable = 1'b1;
        config_load   = 1'b1;
        tick();
        config_enable = 1'b0;
        config_load   = 1'b0;
        dic           = '0;
        dic[5]        = 1'b1;
        data_from_ic  = dic;
        // Active holds A: pad 0 routes track 5. Chain moved by one: next bit out is A[1].
        sb.push_back('{nm: "simul_oe_a",    exp: 64'(4'b0001)});
        sb.push_back('{nm: "simul_to_io_a", exp: 64'(4'b0001)});
        sb.push_back('{nm: "simul_cfg_out", exp: 64'(1'b0)});
        #1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       obs = 64'(data_oe);
                1:       obs = 64'(data_to_io);
                default: obs = 64'(config_out);
            endcase
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
            end
        end
        load_cfg();
        // Shifted A: pad 1 oe comes from A[12], routing track 0 combinationally.
        dic          = '0;
        dic[0]       = 1'b1;
        data_from_ic = dic;
        sb.push_back('{nm: "simul_oe_shifted",    exp: 64'(4'b0010)});
        sb.push_back('{nm: "simul_to_io_shifted", exp: 64'(4'b0010)});
        #1;
        obs = 64'(data_oe);
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
        end
        obs = 64'(data_to_io);
        e = sb.pop_front();
        checks++;
        if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", e.nm, obs, e.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got still_running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        data_from_io  = '0;
        data_from_ic  = '0;
        config_in     = 1'b0;
        config_enable = 1'b0;
        config_load   = 1'b0;
        test_reset();
        test_shift_through();
        test_comb_route();
        test_reg_inv();
        test_oor_track();
        test_simul_shift_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
